freq_equa_coef_feeder: RTL
==========================

// Module: freq_equa_coef_feeder
// PURPOSE
//  Supplies the per-bin 16-bit frequency-equalisation coefficient (para) to the FreqEqua multiplier stage.
//  Coefficient index = cnt_sync_in of the incoming re/im stream; data and sync are delayed to match the RAM read.
//  Host loads a new coefficient set into a shadow bank via a valid/ready stream.
//  Banks swap only at a frame boundary, so a frame never mixes two coefficient sets.
// PARAMETERS
//  BITWIDTH       7        cnt width is BITWIDTH+2 bits (9 bits = 512 bins)
//  FFT_POINT      512      bins per frame; power of two; depth of each coefficient bank
//  SUB_FFT_POINT  512      carried for interface compatibility; no function here
//  PARA_UNITY     16'h4000 coefficient emitted before the first valid bank exists
// PORTS
//  clk           in   1            system clock
//  rst           in   1            synchronous, active-high reset
//  wr_start      in   1            begin loading a new set into the shadow bank
//  wr_valid      in   1            wr_data valid
//  wr_data       in   16           coefficient; bin address auto-increments from 0
//  wr_ready      out  1            shadow bank accepting words
//  wr_done       out  1            1-cycle pulse when FFT_POINT words have been accepted
//  swap_pending  out  1            loaded set is waiting for a frame start
//  bank_sel      out  1            active (read) bank
//  en_sync_in    in   1            frame/sample sync from the FFT
//  cnt_sync_in   in   BITWIDTH+2   bin index of current sample
//  re_in, im_in  in   23           sample
//  en_sync_out   out  1            en_sync_in delayed 2 cycles
//  cnt_sync_out  out  BITWIDTH+2   cnt_sync_in delayed 2 cycles
//  re_out,im_out out  23           re_in/im_in delayed 2 cycles
//  para_out      out  16           coefficient for the bin of re_out/im_out
// BEHAVIOUR
//  Reset: all outputs 0; bank_sel=0; bank_valid=0; write FSM to IDLE. RAM contents are not cleared.
//  Read path, latency 2:
//   - Cycle 0: addr = cnt_sync_in mod FFT_POINT.
//   - Cycle 1: registered RAM read of bank[bank_sel].
//   - Cycle 2: para_out registered.
//   - re/im/en/cnt pass through 2 register stages, unconditionally (not gated by en_sync_in).
//   - bank_valid=0 -> para_out = PARA_UNITY.
//  Frame start (FS) = en_sync_in && cnt_sync_in==0.
//  Write FSM:
//   - IDLE: wr_ready=0; wr_valid ignored; wr_start -> LOAD, waddr=0.
//   - LOAD: wr_ready=1; each wr_valid&&wr_ready writes shadow[waddr], waddr++.
//     Word at waddr==FFT_POINT-1 accepted -> FULL, wr_done=1 for 1 cycle.
//     wr_start in LOAD restarts at waddr=0.
//   - FULL: wr_ready=0; swap_pending=1; wr_start ignored.
//     On FS: bank_sel toggles, bank_valid=1, swap_pending=0, -> IDLE.
//     The FS sample itself reads the new bank.
//  Boundary cases:
//   - Last write and FS in the same cycle: no swap; swap at the next FS.
//   - wr_done and the swap never occur in the same cycle.
//   - Shadow writes never touch the active bank.
//   - Reset mid-load discards the partial set and returns to unity output until the next load+swap.
// CONFIGURATION
//  FREQ_EQUA_BYPASS_EN defined:
//   - Adds input port eq_bypass (1 bit).
//   - eq_bypass=1 -> para_out=PARA_UNITY, same 2-cycle alignment (sampled with cnt_sync_in).
//   - Loading and swapping continue unaffected.
//  Undefined: no port; para_out always from RAM / bank_valid logic.
// TESTING
//  T1 rst, then frame cnt 0..511, en=1, no load -> para_out=16'h4000 throughout;
//     en/cnt/re/im out = in delayed exactly 2 clk.
//  T2 wr_start, 512 back-to-back words wr_data=k -> wr_done 1 clk after word 511; wr_ready=0;
//     at next FS bank_sel=1; para_out=n for cnt_sync_out=n.
//  T3 load 511-k mid-frame -> current frame still yields k; next frame yields 511-k.
//  T4 wr_valid every other cycle plus wr_valid pulses in IDLE -> exactly 512 words stored;
//     IDLE pulses ignored.
//  T5 rst at word 200 -> wr_ready=0, bank_sel=0, para_out=16'h4000; a fresh full load then works.
//  T6 word 511 accepted on the FS cycle -> bank_sel unchanged that frame; toggles at the following FS.

Source files
------------

// File: rtl/freq_equa_coef_feeder.sv
// Double-banked per-bin equaliser coefficient feeder; banks swap only at frame start so a frame never mixes sets.
// Optional eq_bypass port (forces unity coefficient) is built when FREQ_EQUA_BYPASS_EN is defined.
module freq_equa_coef_feeder #(
  parameter int          BITWIDTH      = 7,
  parameter int          FFT_POINT     = 512,
  parameter int          SUB_FFT_POINT = 512,
  parameter logic [15:0] PARA_UNITY    = 16'h4000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_start,
  input  logic                wr_valid,
  input  logic [15:0]         wr_data,
  output logic                wr_ready,
  output logic                wr_done,
  output logic                swap_pending,
  output logic                bank_sel,
`ifdef FREQ_EQUA_BYPASS_EN
  input  logic                eq_bypass,
`endif
  input  logic                en_sync_in,
  input  logic [BITWIDTH+1:0] cnt_sync_in,
  input  logic [22:0]         re_in,
  input  logic [22:0]         im_in,
  output logic                en_sync_out,
  output logic [BITWIDTH+1:0] cnt_sync_out,
  output logic [22:0]         re_out,
  output logic [22:0]         im_out,
  output logic [15:0]         para_out
);

  localparam int AW = $clog2(FFT_POINT);

  if ((1 << AW) != FFT_POINT) begin : g_bad_fft_point
    $error("FFT_POINT must be a power of two");
  end
  if (BITWIDTH + 2 < AW || SUB_FFT_POINT < 1) begin : g_bad_widths
    $error("cnt width too narrow for FFT_POINT, or SUB_FFT_POINT invalid");
  end

  typedef enum logic [1:0] {IDLE, LOAD, FULL} state_t;

  state_t          state;
  logic [AW-1:0]   waddr;
  logic            bank_valid;
  logic [15:0]     mem [0:2*FFT_POINT-1];
  logic [15:0]     rd_q;

  logic            s1_en;
  logic [BITWIDTH+1:0] s1_cnt;
  logic [22:0]     s1_re;
  logic [22:0]     s1_im;
  logic            s1_use_ram;

  logic [AW-1:0]   raddr;
  logic            fs;
  logic            swap;
  logic            rd_bank;
  logic            wr_en;
  logic            byp;

`ifdef FREQ_EQUA_BYPASS_EN
  assign byp = eq_bypass;
`else
  assign byp = 1'b0;
`endif

  assign raddr   = cnt_sync_in[AW-1:0];
  assign fs      = en_sync_in && (cnt_sync_in == '0);
  // Holding off while wr_done is up keeps the done pulse and the swap in separate cycles.
  assign swap    = (state == FULL) && fs && !wr_done;
  // The frame-start sample must already see the new bank, so the read bank is chosen combinationally.
  assign rd_bank = bank_sel ^ swap;
  assign wr_en   = (state == LOAD) && wr_valid && !wr_start;

  // Writes only ever target the inactive bank; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[{~bank_sel, waddr}] <= wr_data;
    end
    rd_q <= mem[{rd_bank, raddr}];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      waddr        <= '0;
      wr_ready     <= 1'b0;
      wr_done      <= 1'b0;
      swap_pending <= 1'b0;
      bank_sel     <= 1'b0;
      bank_valid   <= 1'b0;
    end else begin
      wr_done <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_start) begin
            state    <= LOAD;
            waddr    <= '0;
            wr_ready <= 1'b1;
          end
        end
        LOAD: begin
          if (wr_start) begin
            waddr <= '0;
          end else if (wr_valid) begin
            if (waddr == AW'(FFT_POINT - 1)) begin
              state        <= FULL;
              wr_ready     <= 1'b0;
              wr_done      <= 1'b1;
              swap_pending <= 1'b1;
            end else begin
              waddr <= waddr + 1'b1;
            end
          end
        end
        FULL: begin
          if (swap) begin
            state        <= IDLE;
            bank_sel     <= ~bank_sel;
            bank_valid   <= 1'b1;
            swap_pending <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_en        <= 1'b0;
      s1_cnt       <= '0;
      s1_re        <= '0;
      s1_im        <= '0;
      s1_use_ram   <= 1'b0;
      en_sync_out  <= 1'b0;
      cnt_sync_out <= '0;
      re_out       <= '0;
      im_out       <= '0;
      para_out     <= '0;
    end else begin
      s1_en        <= en_sync_in;
      s1_cnt       <= cnt_sync_in;
      s1_re        <= re_in;
      s1_im        <= im_in;
      s1_use_ram   <= (bank_valid || swap) && !byp;
      en_sync_out  <= s1_en;
      cnt_sync_out <= s1_cnt;
      re_out       <= s1_re;
      im_out       <= s1_im;
      para_out     <= s1_use_ram ? rd_q : PARA_UNITY;
    end
  end

endmodule
